// File: rtl/dma_pcie_cfg_mgmt_arb.sv
`default_nettype none
// ============================================================================
// Module   : dma_pcie_cfg_mgmt_arb
// Purpose  : Round-robin arbiter and sequencer for the PCIe core
//            configuration-management port. NUM_REQ requesters share the
//            single cfg_mgmt channel; one access is in flight at a time, and
//            its read data/status is returned to the owning requester.
// Ports    : user_clk / user_reset_n (async, active-low)
//            req_*        per-requester request bundle, req_ready one-hot grant
//            rsp_*        one-hot completion pulse with read data and error
//            cfg_mgmt_*   access channel to the PCIe core
//            cfg_hot_reset_out  hot-reset indication (aborts/blocks accesses)
//            busy         high while an access is in flight or responding
// Options  : CFG_MGMT_ARB_TIMEOUT_EN - when defined, an access that sees no
//            done within TIMEOUT_CYCLES BUSY cycles is aborted with rsp_err.
// Revision : 1.0 - initial release
// ============================================================================
module dma_pcie_cfg_mgmt_arb #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  user_clk,
  input  logic                  user_reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*10-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]  req_func,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0]  req_be,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [9:0]            cfg_mgmt_addr,
  output logic [7:0]            cfg_mgmt_function_number,
  output logic                  cfg_mgmt_write,
  output logic                  cfg_mgmt_read,
  output logic [31:0]           cfg_mgmt_write_data,
  output logic [3:0]            cfg_mgmt_byte_enable,
  input  logic [31:0]           cfg_mgmt_read_data,
  input  logic                  cfg_mgmt_read_write_done,
  input  logic                  cfg_hot_reset_out,
  output logic                  busy
);

  localparam int IDXW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] owner;

  // Round-robin search: scan from rr_ptr upward, wrapping at NUM_REQ.
  logic [IDXW:0]   cand;
  logic [IDXW-1:0] win_idx;
  logic            win_found;

  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NUM_REQ)) cand = cand - (IDXW+1)'(NUM_REQ);
      if (!win_found && req_valid[cand[IDXW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDXW-1:0];
      end
    end
  end

  // Winner's request fields, selected with constant slices.
  logic        sel_write;
  logic [9:0]  sel_addr;
  logic [7:0]  sel_func;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_be;

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_func  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDXW'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*10 +: 10];
        sel_func  = req_func[i*8 +: 8];
        sel_wdata = req_wdata[i*32 +: 32];
        sel_be    = req_be[i*4 +: 4];
      end
    end
  end

  // Grant is combinational; gating by reset keeps every output low in reset.
  logic grant_en;
  assign grant_en = (state == ST_IDLE) && win_found && !cfg_hot_reset_out && user_reset_n;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = grant_en && (win_idx == IDXW'(gi));
  end

  logic tmo_hit;
`ifdef CFG_MGMT_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;

  // Counts BUSY cycles; held at zero outside BUSY so it restarts per access.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      tmo_cnt <= '0;
    end else if (state != ST_BUSY) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state                    <= ST_IDLE;
      rr_ptr                   <= '0;
      owner                    <= '0;
      rsp_valid                <= '0;
      rsp_rdata                <= '0;
      rsp_err                  <= 1'b0;
      cfg_mgmt_addr            <= '0;
      cfg_mgmt_function_number <= '0;
      cfg_mgmt_write           <= 1'b0;
      cfg_mgmt_read            <= 1'b0;
      cfg_mgmt_write_data      <= '0;
      cfg_mgmt_byte_enable     <= '0;
      busy                     <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_en) begin
            owner                    <= win_idx;
            cfg_mgmt_addr            <= sel_addr;
            cfg_mgmt_function_number <= sel_func;
            cfg_mgmt_write_data      <= sel_wdata;
            cfg_mgmt_byte_enable     <= sel_be;
            cfg_mgmt_write           <= sel_write;
            cfg_mgmt_read            <= !sel_write;
            busy                     <= 1'b1;
            state                    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // done has priority over both abort sources
          if (cfg_mgmt_read_write_done) begin
            cfg_mgmt_write   <= 1'b0;
            cfg_mgmt_read    <= 1'b0;
            rsp_rdata        <= cfg_mgmt_write ? 32'd0 : cfg_mgmt_read_data;
            rsp_err          <= 1'b0;
            rsp_valid[owner] <= 1'b1;
            state            <= ST_RESP;
          end else if (cfg_hot_reset_out || tmo_hit) begin
            cfg_mgmt_write   <= 1'b0;
            cfg_mgmt_read    <= 1'b0;
            rsp_rdata        <= 32'd0;
            rsp_err          <= 1'b1;
            rsp_valid[owner] <= 1'b1;
            state            <= ST_RESP;
          end
        end
        ST_RESP: begin
          rr_ptr <= (owner == IDXW'(NUM_REQ - 1)) ? '0 : owner + IDXW'(1);
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_pcie_cfg_mgmt_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_pcie_cfg_mgmt_arb
// Purpose  : Self-checking bench for dma_pcie_cfg_mgmt_arb (NUM_REQ=2).
//            A transaction-level model predicts grants, strobes, fields and
//            responses every cycle; directed scenarios add literal checks.
//            Honours CFG_MGMT_ARB_TIMEOUT_EN for the timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_pcie_cfg_mgmt_arb;

  localparam int N   = 2;
  localparam int TMO = 16;

  logic          user_clk = 1'b0;
  logic          user_reset_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  req_write = '0;
  logic [N*10-1:0] req_addr = '0;
  logic [N*8-1:0]  req_func = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N*4-1:0]  req_be = '0;
  logic [N-1:0]  rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [9:0]    cfg_mgmt_addr;
  logic [7:0]    cfg_mgmt_function_number;
  logic          cfg_mgmt_write;
  logic          cfg_mgmt_read;
  logic [31:0]   cfg_mgmt_write_data;
  logic [3:0]    cfg_mgmt_byte_enable;
  logic [31:0]   cfg_mgmt_read_data = 32'h10EE9038;
  logic          cfg_mgmt_read_write_done = 1'b0;
  logic          cfg_hot_reset_out = 1'b0;
  logic          busy;

  dma_pcie_cfg_mgmt_arb #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_func(req_func), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cfg_mgmt_addr(cfg_mgmt_addr), .cfg_mgmt_function_number(cfg_mgmt_function_number),
    .cfg_mgmt_write(cfg_mgmt_write), .cfg_mgmt_read(cfg_mgmt_read),
    .cfg_mgmt_write_data(cfg_mgmt_write_data), .cfg_mgmt_byte_enable(cfg_mgmt_byte_enable),
    .cfg_mgmt_read_data(cfg_mgmt_read_data),
    .cfg_mgmt_read_write_done(cfg_mgmt_read_write_done),
    .cfg_hot_reset_out(cfg_hot_reset_out), .busy(busy)
  );

  always #5 user_clk = ~user_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired, event not seen", nm);
  endtask

  // ---------------- core responder: done on the done_lat-th strobe cycle
  int done_lat = 1;
  int scnt = 0;
  initial begin
    forever begin
      @(posedge user_clk);
      #1;
      if (!user_reset_n || !(cfg_mgmt_read || cfg_mgmt_write)) begin
        scnt = 0;
        cfg_mgmt_read_write_done = 1'b0;
      end else begin
        scnt++;
        cfg_mgmt_read_write_done = (done_lat != 0) && (scnt == done_lat);
      end
    end
  end

  // ---------------- transaction-level model
  bit          m_active, m_resp;
  int          m_ptr, m_owner, m_cnt;
  logic        m_wr;
  logic [9:0]  m_addr;
  logic [7:0]  m_func;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        m_err;

  // monitor records for directed checks
  int          grant_idx[$];
  int          grant_cyc[$];
  int          cyc = 0;
  int          strobe_run = 0;
  int          last_len = 0;
  logic [N-1:0] last_rsp_valid = '0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  always @(negedge user_clk) begin : compare
    logic [N-1:0] er;
    int pick, j;
    if (!user_reset_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_strobes", {cfg_mgmt_read, cfg_mgmt_write}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fields", {cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write_data,
                         cfg_mgmt_byte_enable}, 0);
      chk("rst_rsp", {rsp_rdata, rsp_err}, 0);
      m_active = 0; m_resp = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
      m_wr = 0; m_addr = 0; m_func = 0; m_wdata = 0; m_be = 0; m_rdata = 0; m_err = 0;
      strobe_run = 0;
    end else begin
      er = '0;
      pick = -1;
      if (!m_active && !m_resp && !cfg_hot_reset_out) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (pick < 0 && req_valid[j]) pick = j;
        end
      end
      if (pick >= 0) er[pick] = 1'b1;
      chk("req_ready", req_ready, er);
      chk("cfg_read", cfg_mgmt_read, m_active && !m_wr);
      chk("cfg_write", cfg_mgmt_write, m_active && m_wr);
      chk("cfg_addr", cfg_mgmt_addr, m_addr);
      chk("cfg_func", cfg_mgmt_function_number, m_func);
      chk("cfg_wdata", cfg_mgmt_write_data, m_wdata);
      chk("cfg_be", cfg_mgmt_byte_enable, m_be);
      chk("busy", busy, m_active || m_resp);
      chk("rsp_valid", rsp_valid, m_resp ? (N'(1) << m_owner) : N'(0));
      if (m_resp) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
      end

      // monitor
      if (req_ready != 0) begin
        grant_idx.push_back(req_ready[1] ? 1 : 0);
        grant_cyc.push_back(cyc);
      end
      if (cfg_mgmt_read || cfg_mgmt_write) strobe_run++;
      else if (strobe_run > 0) begin last_len = strobe_run; strobe_run = 0; end
      if (rsp_valid != 0) begin
        last_rsp_valid = rsp_valid; last_rdata = rsp_rdata; last_err = rsp_err;
      end

      // advance the model to the next cycle
      if (m_resp) begin
        m_resp = 0;
        m_ptr  = (m_owner + 1) % N;
      end else if (m_active) begin
        m_cnt++;
        if (cfg_mgmt_read_write_done) begin
          m_active = 0; m_resp = 1; m_err = 0;
          m_rdata  = m_wr ? 32'd0 : cfg_mgmt_read_data;
        end else if (cfg_hot_reset_out) begin
          m_active = 0; m_resp = 1; m_err = 1; m_rdata = 0;
        end
`ifdef CFG_MGMT_ARB_TIMEOUT_EN
        else if (m_cnt == TMO) begin
          m_active = 0; m_resp = 1; m_err = 1; m_rdata = 0;
        end
`endif
      end else if (pick >= 0) begin
        m_active = 1; m_cnt = 0; m_owner = pick;
        m_wr    = req_write[pick];
        m_addr  = req_addr[10*pick +: 10];
        m_func  = req_func[8*pick +: 8];
        m_wdata = req_wdata[32*pick +: 32];
        m_be    = req_be[4*pick +: 4];
      end
      cyc++;
    end
  end

  // ---------------- stimulus helpers
  task automatic set_req(input int i, input logic w, input logic [9:0] a,
                         input logic [7:0] f, input logic [31:0] d, input logic [3:0] b);
    req_write[i]         = w;
    req_addr[10*i +: 10] = a;
    req_func[8*i +: 8]   = f;
    req_wdata[32*i +: 32] = d;
    req_be[4*i +: 4]     = b;
    req_valid[i]         = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    bit got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge user_clk); #1;
      if (req_ready[i]) got = 1;
    end
    if (!got) bound_fail("grant_wait");
    @(posedge user_clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i);
    bit got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge user_clk); #1;
      if (rsp_valid[i]) got = 1;
    end
    if (!got) bound_fail("rsp_wait");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n0;
    bit got;
    repeat (3) @(posedge user_clk);
    #1 user_reset_n = 1'b1;
    repeat (2) @(posedge user_clk);
    #1;

    // Fairness: both requesters continuously valid, done latency 1
    done_lat = 1;
    set_req(0, 1'b0, 10'h010, 8'h00, 32'h0, 4'h0);
    set_req(1, 1'b0, 10'h020, 8'h01, 32'h0, 4'h0);
    for (int c = 0; c < 40 && grant_idx.size() < 4; c++) begin
      @(negedge user_clk); #1;
    end
    @(posedge user_clk); #1;
    req_valid = '0;
    if (grant_idx.size() < 4) bound_fail("fair_grants");
    else begin
      chk("fair_g0", grant_idx[0], 0);
      chk("fair_g1", grant_idx[1], 1);
      chk("fair_g2", grant_idx[2], 0);
      chk("fair_g3", grant_idx[3], 1);
      chk("fair_gap1", grant_cyc[1] - grant_cyc[0], 3);
      chk("fair_gap2", grant_cyc[2] - grant_cyc[1], 3);
      chk("fair_gap3", grant_cyc[3] - grant_cyc[2], 3);
    end
    wait_rsp(1);

    // Single read from requester 0, done on third strobe cycle
    done_lat = 3;
    set_req(0, 1'b0, 10'h004, 8'h00, 32'h0, 4'h0);
    wait_grant(0);
    wait_rsp(0);
    chk("rd_rsp_valid", last_rsp_valid, 2'b01);
    chk("rd_rdata", last_rdata, 32'h10EE9038);
    chk("rd_err", last_err, 0);
    chk("rd_strobe_len", last_len, 3);

    // Write from requester 1
    done_lat = 2;
    set_req(1, 1'b1, 10'h3FF, 8'h07, 32'hA5A5A5A5, 4'h3);
    wait_grant(1);
    @(negedge user_clk); #1;
    chk("wr_strobe", {cfg_mgmt_write, cfg_mgmt_read}, 2'b10);
    chk("wr_addr", cfg_mgmt_addr, 10'h3FF);
    chk("wr_func", cfg_mgmt_function_number, 8'h07);
    chk("wr_data", cfg_mgmt_write_data, 32'hA5A5A5A5);
    chk("wr_be", cfg_mgmt_byte_enable, 4'h3);
    wait_rsp(1);
    chk("wr_rsp_valid", last_rsp_valid, 2'b10);
    chk("wr_rdata", last_rdata, 0);
    chk("wr_err", last_err, 0);

    // Hot reset during BUSY, then held high while requester 1 waits
    done_lat = 0;
    set_req(0, 1'b0, 10'h00C, 8'h00, 32'h0, 4'h0);
    wait_grant(0);
    repeat (2) @(posedge user_clk);
    #1;
    cfg_hot_reset_out = 1'b1;
    set_req(1, 1'b0, 10'h040, 8'h03, 32'h0, 4'h0);
    n0 = grant_idx.size();
    @(negedge user_clk); #1;
    chk("hr_strobe_before", cfg_mgmt_read, 1);
    @(negedge user_clk); #1;
    chk("hr_strobe_after", cfg_mgmt_read, 0);
    chk("hr_rsp_valid", rsp_valid, 2'b01);
    chk("hr_err", rsp_err, 1);
    chk("hr_rdata", rsp_rdata, 0);
    repeat (5) @(negedge user_clk);
    #1;
    chk("hr_no_grant", grant_idx.size(), n0);
    @(posedge user_clk); #1;
    cfg_hot_reset_out = 1'b0;
    done_lat = 2;
    wait_grant(1);
    wait_rsp(1);
    chk("hr_after_err", last_err, 0);

    // Timeout (or indefinite wait without the feature)
    done_lat = 0;
    set_req(0, 1'b0, 10'h008, 8'h00, 32'h0, 4'h0);
    wait_grant(0);
`ifdef CFG_MGMT_ARB_TIMEOUT_EN
    wait_rsp(0);
    chk("tmo_strobe_len", last_len, TMO);
    chk("tmo_err", last_err, 1);
    chk("tmo_rdata", last_rdata, 0);
`else
    repeat (1000) @(negedge user_clk);
    #1;
    chk("notmo_strobe_high", cfg_mgmt_read, 1);
    @(posedge user_clk); #1;
    cfg_hot_reset_out = 1'b1;
    wait_rsp(0);
    chk("notmo_abort_err", last_err, 1);
    @(posedge user_clk); #1;
    cfg_hot_reset_out = 1'b0;
`endif

    // Reset asserted mid-access
    done_lat = 0;
    set_req(1, 1'b0, 10'h100, 8'h02, 32'h0, 4'h0);
    wait_grant(1);
    @(posedge user_clk);
    #3 user_reset_n = 1'b0;
    #1;
    chk("arst_strobe", {cfg_mgmt_read, cfg_mgmt_write}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge user_clk);
    #1 user_reset_n = 1'b1;
    done_lat = 1;
    set_req(0, 1'b0, 10'h001, 8'h00, 32'h0, 4'h0);
    set_req(1, 1'b0, 10'h002, 8'h01, 32'h0, 4'h0);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge user_clk); #1;
      if (req_ready != 0) got = 1;
    end
    if (!got) bound_fail("post_reset_grant");
    else chk("post_reset_first", req_ready, 2'b01);
    @(posedge user_clk); #1;
    req_valid = '0;
    wait_rsp(0);
    repeat (3) @(negedge user_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_pcie_cfg_mgmt_arb.md
# dma_pcie_cfg_mgmt_arb

Round-robin arbiter and sequencer for the PCIe core configuration-management port. It lets up to NUM_REQ internal requesters share the single cfg_mgmt read/write channel, such as the register bridge, the FLR handler and the MSI-X setup logic. It drives one access at a time, waits for cfg_mgmt_read_write_done, and returns read data and status to the owning requester. It sits beside the misc-input bundle and consumes the cfg_mgmt_read_data, cfg_mgmt_read_write_done and cfg_hot_reset_out signals from that bundle.

## Interface
Parameters:
- NUM_REQ, default 2: number of requesters, legal range 2..8.
- TIMEOUT_CYCLES, default 255: maximum cycles an access stays in BUSY; width 8..16 bits; only used when the timeout feature is compiled in.

Ports:
- user_clk  in  1  single clock for the block.
- user_reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester access request; held until the matching req_ready.
- req_ready  out  NUM_REQ  one-hot grant; request fields are captured in the same cycle.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*10  DWORD register number, packed with requester i at [10i+9:10i].
- req_func  in  NUM_REQ*8  target function number.
- req_wdata  in  NUM_REQ*32  write data.
- req_be  in  NUM_REQ*4  write byte enables.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to the owning requester.
- rsp_rdata  out  32  read data; 0 for writes and for errored accesses.
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout or hot-reset abort.
- cfg_mgmt_addr  out  10  register number to the core.
- cfg_mgmt_function_number  out  8  function number to the core.
- cfg_mgmt_write  out  1  write strobe to the core.
- cfg_mgmt_read  out  1  read strobe to the core.
- cfg_mgmt_write_data  out  32  write data to the core.
- cfg_mgmt_byte_enable  out  4  byte enables to the core.
- cfg_mgmt_read_data  in  32  read data from the core.
- cfg_mgmt_read_write_done  in  1  access completion from the core.
- cfg_hot_reset_out  in  1  hot reset indication from the core.
- busy  out  1  high in the BUSY and RESP states.

## Operation
- The FSM has three states: IDLE, BUSY and RESP.
- IDLE:
  - If any req_valid is set and cfg_hot_reset_out is 0, select the winner by round-robin, starting from the requester after the last one served.
  - Assert req_ready[winner] combinationally in that cycle.
  - Register the winner's fields and owner index, then go to BUSY.
- BUSY:
  - Hold cfg_mgmt_read or cfg_mgmt_write (registered) and the address, function, data and byte-enable fields stable.
  - On cfg_mgmt_read_write_done: drop the strobe, capture cfg_mgmt_read_data (reads only; writes capture 0), clear rsp_err, go to RESP.
  - On cfg_hot_reset_out=1 without done in the same cycle: drop the strobe, set rsp_err=1, set rdata=0, go to RESP.
  - If done and hot reset arrive together, done wins.
- RESP:
  - Pulse rsp_valid[owner] for one cycle.
  - Set the round-robin pointer to owner+1, wrapping from NUM_REQ-1 to 0.
  - Return to IDLE.
- cfg_mgmt_read_write_done seen in IDLE or RESP is ignored.
- A requester that drops req_valid before its grant is legal; it simply receives no grant.
- Reset values:
  - All outputs are 0.
  - The state is IDLE.
  - The round-robin pointer is 0, so requester 0 has first priority.
  - The owner index is 0.

## Timing
- Grant at cycle T; the strobe is high from T+1.
- Done arrives at T+k (k ≥ 1); the strobe is low at T+k+1; rsp_valid is high at T+k+1.
- IDLE at T+k+2, so the next grant can occur no earlier than T+k+2.
- rsp_rdata and rsp_err are valid only while rsp_valid is high; they hold their values otherwise.
- Reset asserted mid-access drops the strobe immediately (asynchronously) and no response is issued.

## Configuration
- CFG_MGMT_ARB_TIMEOUT_EN defined:
  - A BUSY-cycle counter clears on entry to BUSY.
  - If the counter reaches TIMEOUT_CYCLES without done, drop the strobe, set rsp_err=1, rdata=0, and go to RESP.
  - If done arrives in the same cycle as the terminal count, done wins.
- CFG_MGMT_ARB_TIMEOUT_EN undefined: there is no counter, and BUSY waits indefinitely for done or cfg_hot_reset_out.

## Test plan
- Single read: req0 reads addr 0x004, func 0; core returns 0x10EE9038 with done 3 cycles after the strobe → strobe high for exactly 3 cycles, rsp_valid=01, rsp_rdata=0x10EE9038, rsp_err=0.
- Fairness: req0 and req1 continuously valid, done latency 1 → grants alternate 0,1,0,1; each grant is 3 cycles apart.
- Write: req1 writes 0xA5A5A5A5, BE=0x3, addr 0x3FF, func 7 → core sees these exact values; response rsp_valid=10, rdata=0, err=0.
- Hot reset: cfg_hot_reset_out pulses during BUSY → strobe low next cycle, rsp_err=1, rdata=0; no grant issued while the hot reset stays high.
- Timeout (macro on, TIMEOUT_CYCLES=16): done never arrives → strobe high for 16 cycles, then rsp_err=1. With the macro off, the strobe is still high after 1000 cycles.
- Reset mid-access: user_reset_n low during BUSY → all outputs 0 at once; after release, the first grant goes to requester 0.
